// File: rtl/mult_share_arbiter.sv
// Round-robin sequencer that shares one sequential multiplier among N_REQ clients.
// It grants one client, issues a start pulse, waits for done under a watchdog, then routes the result back.
module mult_share_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DW      = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*DW-1:0]   op_a,
    input  logic [N_REQ*DW-1:0]   op_b,
    output logic [N_REQ-1:0]      gnt,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [2*DW-1:0]       rsp_data,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  mul_start,
    output logic [DW-1:0]         mul_a,
    output logic [DW-1:0]         mul_b,
    input  logic                  mul_done,
    input  logic [2*DW-1:0]       mul_result
);
    localparam int PW = $clog2(N_REQ);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] idx;
    logic [TW-1:0] timer;
    logic [PW-1:0] win;
    logic          found;
    int            j;

    // Scan from the highest offset down so the offset closest to ptr wins.
    always_comb begin
        win   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N_REQ;
            if (req[j]) begin
                win   = PW'(j);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            idx       <= '0;
            timer     <= '0;
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            mul_start <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
        end else begin
            gnt       <= '0;
            rsp_valid <= '0;
            mul_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        idx   <= win;
                        mul_a <= op_a[win*DW +: DW];
                        mul_b <= op_b[win*DW +: DW];
                        gnt   <= ONE << win;
                        ptr   <= (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;
                        busy  <= 1'b1;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    mul_start <= 1'b1;
                    timer     <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    timer <= timer + 1'b1;
                    // done takes precedence over a coincident watchdog expiry
                    if (mul_done) begin
                        rsp_data  <= mul_result;
                        rsp_err   <= 1'b0;
                        rsp_valid <= ONE << idx;
                        state     <= RESP;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= ONE << idx;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
